// File: rtl/speed_ctrl_pkg.sv
// Shared types for the playback speed controller: auto-repeat FSM states
// and the resolved key direction.
package speed_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } speed_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } speed_dir_t;

endpackage

// File: rtl/key_autorepeat.sv
// Hold-to-repeat engine: a fresh press steps once, waits REPEAT_DELAY cycles,
// then steps every REPEAT_PERIOD cycles while the same direction stays held.
module key_autorepeat
  import speed_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY  = 13500000,
  parameter int REPEAT_PERIOD = 2700000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  speed_dir_t   i_dir,
  input  logic         i_up_level,
  input  logic         i_dn_level,
  input  logic         i_speed_reset_event,
  output logic         o_step_pulse,
  output speed_dir_t   o_step_dir,
  output speed_state_t o_state
);

  localparam int LP_TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TIMER_W = $clog2(LP_TMAX + 1);
  localparam logic [TIMER_W-1:0] LP_DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] LP_PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

  speed_state_t       r_state;
  speed_dir_t         r_dir;
  logic [TIMER_W-1:0] r_timer;
  logic               r_prev_up;
  logic               r_prev_dn;

  logic w_rise;
  logic w_held;

  // Only a genuine press re-arms; a key left held across a return to IDLE
  // shows no rising edge and therefore stays silent.
  assign w_rise = ((i_dir == DIR_UP) && i_up_level && !r_prev_up) ||
                  ((i_dir == DIR_DN) && i_dn_level && !r_prev_dn);
  assign w_held = (i_dir == r_dir);
  assign o_state = r_state;

  always_comb begin
    o_step_pulse = 1'b0;
    o_step_dir   = r_dir;
    case (r_state)
      IDLE: begin
        o_step_pulse = w_rise;
        o_step_dir   = i_dir;
      end
      HOLD_WAIT: o_step_pulse = w_held && (r_timer == LP_DELAY_LAST);
      REPEAT:    o_step_pulse = w_held && (r_timer == LP_PERIOD_LAST);
      default:   o_step_pulse = 1'b0;
    endcase
    if (i_speed_reset_event) o_step_pulse = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_dir     <= DIR_NONE;
      r_timer   <= '0;
      r_prev_up <= 1'b0;
      r_prev_dn <= 1'b0;
    end else begin
      r_prev_up <= i_up_level;
      r_prev_dn <= i_dn_level;
      if (i_speed_reset_event) begin
        r_state <= IDLE;
        r_timer <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_timer <= '0;
            if (w_rise) begin
              r_state <= HOLD_WAIT;
              r_dir   <= i_dir;
            end
          end
          HOLD_WAIT: begin
            if (!w_held) begin
              r_state <= IDLE;
              r_timer <= '0;
            end else if (r_timer == LP_DELAY_LAST) begin
              r_state <= REPEAT;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          REPEAT: begin
            if (!w_held) begin
              r_state <= IDLE;
              r_timer <= '0;
            end else if (r_timer == LP_PERIOD_LAST) begin
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/speed_control_ar.sv
// Playback speed controller: turns speed keys into a saturating divider count
// for the sample-rate divider, with hold-to-repeat and a speed-reset pulse.
module speed_control_ar
  import speed_ctrl_pkg::*;
#(
  parameter int COUNT_W       = 16,
  parameter int DEFAULT_COUNT = 614,
  parameter int MIN_COUNT     = 1,
  parameter int MAX_COUNT     = 32767,
  parameter int STEP          = 1,
  parameter int REPEAT_DELAY  = 13500000,
  parameter int REPEAT_PERIOD = 2700000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               speed_up_level,
  input  logic               speed_down_level,
  input  logic               speed_reset_event,
  output logic [COUNT_W-1:0] div_clk_count,
  output logic               at_min,
  output logic               at_max,
  output logic               count_update,
  output speed_state_t       dbg_state
);

  if (!(MIN_COUNT >= 1 && MIN_COUNT <= DEFAULT_COUNT && DEFAULT_COUNT <= MAX_COUNT &&
        longint'(MAX_COUNT) < (longint'(1) << COUNT_W))) begin : g_bad_limits
    $error("speed_control_ar: illegal MIN/DEFAULT/MAX_COUNT for COUNT_W");
  end
  if (!(STEP >= 1 && REPEAT_DELAY >= 2 && REPEAT_PERIOD >= 1)) begin : g_bad_timing
    $error("speed_control_ar: illegal STEP/REPEAT_DELAY/REPEAT_PERIOD");
  end

  localparam logic [COUNT_W:0]   LP_STEP = (COUNT_W+1)'(STEP);
  localparam logic [COUNT_W:0]   LP_MIN  = (COUNT_W+1)'(MIN_COUNT);
  localparam logic [COUNT_W:0]   LP_MAX  = (COUNT_W+1)'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] LP_DEF  = COUNT_W'(DEFAULT_COUNT);

  logic [COUNT_W-1:0] r_count;
  logic               r_at_min;
  logic               r_at_max;
  logic               r_update;

  speed_dir_t         w_dir;
  logic               w_step_pulse;
  speed_dir_t         w_step_dir;
  logic [COUNT_W:0]   w_ext;
  logic [COUNT_W-1:0] w_next;

  always_comb begin
    w_dir = DIR_NONE;
    if (speed_up_level && !speed_down_level) w_dir = DIR_UP;
    else if (speed_down_level && !speed_up_level) w_dir = DIR_DN;
  end

  key_autorepeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_dir               (w_dir),
    .i_up_level          (speed_up_level),
    .i_dn_level          (speed_down_level),
    .i_speed_reset_event (speed_reset_event),
    .o_step_pulse        (w_step_pulse),
    .o_step_dir          (w_step_dir),
    .o_state             (dbg_state)
  );

  // One extra bit keeps count-STEP and count+STEP from wrapping before the clamp.
  assign w_ext = {1'b0, r_count};

  always_comb begin
    w_next = r_count;
    if (speed_reset_event) begin
      w_next = LP_DEF;
    end else if (w_step_pulse && (w_step_dir == DIR_UP)) begin
      w_next = (w_ext >= LP_MIN + LP_STEP) ? COUNT_W'(w_ext - LP_STEP) : COUNT_W'(LP_MIN);
    end else if (w_step_pulse && (w_step_dir == DIR_DN)) begin
      w_next = (w_ext + LP_STEP > LP_MAX) ? COUNT_W'(LP_MAX) : COUNT_W'(w_ext + LP_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= LP_DEF;
      r_at_min <= (DEFAULT_COUNT == MIN_COUNT);
      r_at_max <= (DEFAULT_COUNT == MAX_COUNT);
      r_update <= 1'b0;
    end else begin
      r_count  <= w_next;
      r_at_min <= ({1'b0, w_next} == LP_MIN);
      r_at_max <= ({1'b0, w_next} == LP_MAX);
      r_update <= (w_next != r_count);
    end
  end

  assign div_clk_count = r_count;
  assign at_min        = r_at_min;
  assign at_max        = r_at_max;
  assign count_update  = r_update;

endmodule

// File: tb/tb_speed_control_ar.sv
// Bench for speed_control_ar: a STEP=1 and a STEP=1000 instance, both with a
// short repeat timing, driven by directed scenarios and random key activity.
module tb_speed_control_ar;
  import speed_ctrl_pkg::*;

  localparam int DLY = 8;
  localparam int PER = 4;
  localparam int DEF = 614;
  localparam int MINC = 1;
  localparam int MAXC = 32767;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic up_a = 0, dn_a = 0, rev_a = 0;
  logic up_b = 0, dn_b = 0, rev_b = 0;
  logic [15:0] cnt_a, cnt_b;
  logic min_a, max_a, upd_a, min_b, max_b, upd_b;
  speed_state_t st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;

  speed_control_ar #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) u_dut_a (
    .clk(clk), .rst(rst), .speed_up_level(up_a), .speed_down_level(dn_a),
    .speed_reset_event(rev_a), .div_clk_count(cnt_a), .at_min(min_a),
    .at_max(max_a), .count_update(upd_a), .dbg_state(st_a));

  speed_control_ar #(.STEP(1000), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) u_dut_b (
    .clk(clk), .rst(rst), .speed_up_level(up_b), .speed_down_level(dn_b),
    .speed_reset_event(rev_b), .div_clk_count(cnt_b), .at_min(min_b),
    .at_max(max_b), .count_update(upd_b), .dbg_state(st_b));

  // Reference model: a press steps immediately; while the same direction stays
  // held, further steps fall at hold ages DLY, DLY+PER, DLY+2*PER, ...
  typedef struct {
    int count;
    bit armed;
    int adir;
    int age;
    bit pu;
    bit pd;
    bit upd;
  } model_t;

  model_t m_a, m_b;

  function automatic void model_reset(inout model_t m);
    m.count = DEF; m.armed = 0; m.adir = 0; m.age = 0; m.pu = 0; m.pd = 0; m.upd = 0;
  endfunction

  function automatic void model_step(inout model_t m, input bit up, input bit dn,
                                     input bit rev, input int step);
    int dir;
    bit fire;
    int nxt;
    dir = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
    fire = 0;
    if (rev) begin
      m.armed = 0;
    end else if (m.armed) begin
      if (dir == m.adir) begin
        m.age++;
        fire = (m.age >= DLY) && (((m.age - DLY) % PER) == 0);
      end else begin
        m.armed = 0;
      end
    end else if ((dir == 1 && !m.pu) || (dir == 2 && !m.pd)) begin
      m.armed = 1; m.adir = dir; m.age = 0; fire = 1;
    end
    nxt = m.count;
    if (rev) nxt = DEF;
    else if (fire && m.adir == 1) nxt = (m.count - step < MINC) ? MINC : m.count - step;
    else if (fire) nxt = (m.count + step > MAXC) ? MAXC : m.count + step;
    m.upd = (nxt != m.count);
    m.count = nxt;
    m.pu = up;
    m.pd = dn;
  endfunction

  function automatic logic [18:0] exp_pack(input model_t m);
    logic [15:0] c;
    c = m.count[15:0];
    return {c, m.count == MINC, m.count == MAXC, m.upd};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset(m_a);
      model_reset(m_b);
    end else begin
      model_step(m_a, up_a, dn_a, rev_a, 1);
      model_step(m_b, up_b, dn_b, rev_b, 1000);
    end
  end

  // Driver: inputs change on the falling edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    repeat (5) tick();
    n_cmp++;
    if ({cnt_a, min_a, max_a, upd_a, st_a} !== {16'd614, 3'b000, IDLE}) begin
      n_err++;
      $display("FAIL reset_a: count=%0d min=%b max=%b upd=%b st=%0d want 614/0/0/0/IDLE",
               cnt_a, min_a, max_a, upd_a, st_a);
    end
    n_cmp++;
    if ({cnt_b, min_b, max_b, upd_b, st_b} !== {16'd614, 3'b000, IDLE}) begin
      n_err++;
      $display("FAIL reset_b: count=%0d min=%b max=%b upd=%b st=%0d want 614/0/0/0/IDLE",
               cnt_b, min_b, max_b, upd_b, st_b);
    end
  endtask

  task automatic test_up_pulse();
    up_a = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) up_a = 0;
      tick();
      n_cmp++;
      if (cnt_a !== 16'd613 || upd_a !== (i == 0)) begin
        n_err++;
        $display("FAIL up_pulse[%0d]: count=%0d upd=%b want 613/%b", i, cnt_a, upd_a, i == 0);
      end
    end
  endtask

  task automatic test_down_hold();
    int exp_cnt;
    bit exp_upd;
    rev_a = 1; tick(); rev_a = 0;
    n_cmp++;
    if (cnt_a !== 16'd614 || upd_a !== 1'b1) begin
      n_err++;
      $display("FAIL speed_reset: count=%0d upd=%b want 614/1", cnt_a, upd_a);
    end
    dn_a = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_upd = (i == 1 || i == 9 || i == 13 || i == 17);
      exp_cnt = 614 + int'(i >= 1) + int'(i >= 9) + int'(i >= 13) + int'(i >= 17);
      n_cmp++;
      if (cnt_a !== exp_cnt[15:0] || upd_a !== exp_upd) begin
        n_err++;
        $display("FAIL down_hold[%0d]: count=%0d upd=%b want %0d/%b", i, cnt_a, upd_a, exp_cnt, exp_upd);
      end
    end
    dn_a = 0; tick(); tick();
    n_cmp++;
    if (cnt_a !== 16'd618 || upd_a !== 1'b0 || st_a !== IDLE) begin
      n_err++;
      $display("FAIL down_release: count=%0d upd=%b st=%0d want 618/0/IDLE", cnt_a, upd_a, st_a);
    end
  endtask

  task automatic test_clamp();
    up_b = 1; tick(); up_b = 0;
    n_cmp++;
    if ({cnt_b, min_b, max_b, upd_b} !== {16'd1, 3'b101}) begin
      n_err++;
      $display("FAIL clamp_min: count=%0d min=%b upd=%b want 1/1/1", cnt_b, min_b, upd_b);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); up_b = 1; tick(); up_b = 0;
      n_cmp++;
      if ({cnt_b, min_b, max_b, upd_b} !== {16'd1, 3'b100}) begin
        n_err++;
        $display("FAIL clamp_hold[%0d]: count=%0d min=%b upd=%b want 1/1/0", i, cnt_b, min_b, upd_b);
      end
    end
    tick(); dn_b = 1; tick(); dn_b = 0;
    n_cmp++;
    if ({cnt_b, min_b, max_b, upd_b} !== {16'd1001, 3'b001}) begin
      n_err++;
      $display("FAIL clamp_down: count=%0d min=%b upd=%b want 1001/0/1", cnt_b, min_b, upd_b);
    end
    tick();
  endtask

  task automatic test_reset_during_repeat();
    rev_a = 1; tick(); rev_a = 0;
    up_a = 1;
    repeat (16) tick();
    n_cmp++;
    if (cnt_a !== 16'd611 || st_a !== REPEAT) begin
      n_err++;
      $display("FAIL pre_reset_repeat: count=%0d st=%0d want 611/REPEAT", cnt_a, st_a);
    end
    rev_a = 1; tick(); rev_a = 0;
    n_cmp++;
    if (cnt_a !== 16'd614 || upd_a !== 1'b1 || st_a !== IDLE) begin
      n_err++;
      $display("FAIL reset_vs_step: count=%0d upd=%b st=%0d want 614/1/IDLE", cnt_a, upd_a, st_a);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (cnt_a !== 16'd614 || upd_a !== 1'b0) begin
        n_err++;
        $display("FAIL still_held[%0d]: count=%0d upd=%b want 614/0", i, cnt_a, upd_a);
      end
    end
    up_a = 0; tick(); up_a = 1; tick(); up_a = 0;
    n_cmp++;
    if (cnt_a !== 16'd613 || upd_a !== 1'b1) begin
      n_err++;
      $display("FAIL repress: count=%0d upd=%b want 613/1", cnt_a, upd_a);
    end
    tick();
  endtask

  task automatic test_both_keys();
    up_a = 1; dn_a = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (cnt_a !== 16'd613 || upd_a !== 1'b0 || st_a !== IDLE) begin
        n_err++;
        $display("FAIL both_idle[%0d]: count=%0d upd=%b st=%0d want 613/0/IDLE", i, cnt_a, upd_a, st_a);
      end
    end
    up_a = 0; dn_a = 0; tick();
    up_a = 1;
    repeat (11) tick();
    n_cmp++;
    if (cnt_a !== 16'd611 || st_a !== REPEAT) begin
      n_err++;
      $display("FAIL up_into_repeat: count=%0d st=%0d want 611/REPEAT", cnt_a, st_a);
    end
    dn_a = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) dn_a = 0;
      tick();
      n_cmp++;
      if (cnt_a !== 16'd611 || upd_a !== 1'b0 || st_a !== IDLE) begin
        n_err++;
        $display("FAIL both_mid_repeat[%0d]: count=%0d upd=%b st=%0d want 611/0/IDLE", i, cnt_a, upd_a, st_a);
      end
    end
    up_a = 0; tick();
  endtask

  task automatic test_rst_mid_repeat();
    up_a = 1;
    repeat (14) tick();
    n_cmp++;
    if (st_a !== REPEAT) begin
      n_err++;
      $display("FAIL pre_rst_state: st=%0d want REPEAT", st_a);
    end
    rst = 1; tick();
    n_cmp++;
    if ({cnt_a, min_a, max_a, upd_a, st_a} !== {16'd614, 3'b000, IDLE}) begin
      n_err++;
      $display("FAIL rst_mid_repeat_a: count=%0d min=%b max=%b upd=%b st=%0d want 614/0/0/0/IDLE",
               cnt_a, min_a, max_a, upd_a, st_a);
    end
    n_cmp++;
    if ({cnt_b, min_b, max_b, upd_b} !== {16'd614, 3'b000}) begin
      n_err++;
      $display("FAIL rst_mid_repeat_b: count=%0d upd=%b want 614/0", cnt_b, upd_b);
    end
    up_a = 0; rst = 0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) up_a = ~up_a;
      if ($urandom_range(0, 11) == 0) dn_a = ~dn_a;
      rev_a = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) up_b = ~up_b;
      if ($urandom_range(0, 6) == 0) dn_b = ~dn_b;
      rev_b = ($urandom_range(0, 79) == 0);
      tick();
      n_cmp++;
      if ({cnt_a, min_a, max_a, upd_a} !== exp_pack(m_a)) begin
        n_err++;
        $display("FAIL random_a[%0d]: count/min/max/upd=%0d/%b%b%b want %0d/%b", i,
                 cnt_a, min_a, max_a, upd_a, m_a.count, exp_pack(m_a) & 19'h7);
      end
      n_cmp++;
      if ({cnt_b, min_b, max_b, upd_b} !== exp_pack(m_b)) begin
        n_err++;
        $display("FAIL random_b[%0d]: count/min/max/upd=%0d/%b%b%b want %0d/%b", i,
                 cnt_b, min_b, max_b, upd_b, m_b.count, exp_pack(m_b) & 19'h7);
      end
    end
    up_a = 0; dn_a = 0; rev_a = 0; up_b = 0; dn_b = 0; rev_b = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_up_pulse();
    test_down_hold();
    test_clamp();
    test_reset_during_repeat();
    test_both_keys();
    test_rst_mid_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/speed_control_ar.md
Name: speed_control_ar

Overview:
- Parametrised successor to the playback speed controller. Produces the sample-clock divider count for the audio path from user speed keys.
- Adds configurable width, limits and step size, plus true saturation: a limit clamps further steps but never locks the block.
- Adds hold-to-repeat: a held key steps once, waits, then auto-repeats.
- Sits between the key debouncers and the sample-rate divider; its count also feeds the hex display.

Parameters:
- COUNT_W, 16: width of div_clk_count.
- DEFAULT_COUNT, 614: count after reset or speed reset (22 kHz from 27 MHz).
- MIN_COUNT, 1: lowest count (fastest playback).
- MAX_COUNT, 32767: highest count (slowest playback).
- STEP, 1: count change per step.
- REPEAT_DELAY, 13500000: cycles a key is held before the first auto-repeat step.
- REPEAT_PERIOD, 2700000: cycles between auto-repeat steps.
- Legality: 1 <= MIN_COUNT <= DEFAULT_COUNT <= MAX_COUNT < 2^COUNT_W; STEP >= 1; REPEAT_DELAY >= 2; REPEAT_PERIOD >= 1. Checked by elaboration-time assertions.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- speed_up_level  in  1  debounced level of the speed-up key; each step decreases the count.
- speed_down_level  in  1  debounced level of the speed-down key; each step increases the count.
- speed_reset_event  in  1  single-cycle pulse; restores DEFAULT_COUNT.
- div_clk_count  out  COUNT_W  current divider count, registered.
- at_min  out  1  high while div_clk_count == MIN_COUNT.
- at_max  out  1  high while div_clk_count == MAX_COUNT.
- count_update  out  1  one-cycle pulse whenever div_clk_count changed in this cycle.

Behaviour:
- Reset (rst high at a clk edge):
  - div_clk_count = DEFAULT_COUNT, count_update = 0.
  - at_min/at_max set per DEFAULT_COUNT.
  - FSM to IDLE, timer = 0, previous-level registers = 0.
- Direction:
  - dir_up = up_level & ~down_level; dir_dn = down_level & ~up_level.
  - Both high or both low means no direction.
- FSM states: IDLE, HOLD_WAIT, REPEAT.
  - IDLE: on a rising edge of the active direction's level (level high now, low last cycle), issue one step and go to HOLD_WAIT with timer = 0.
  - HOLD_WAIT: timer increments each cycle. At timer == REPEAT_DELAY-1, issue a step, go to REPEAT, timer = 0.
  - REPEAT: timer increments. At timer == REPEAT_PERIOD-1, issue a step and timer = 0.
  - In HOLD_WAIT or REPEAT, if the direction is lost or changes, go to IDLE with no step.
  - A key still held after returning to IDLE does not step again until it has been released and re-pressed.
- Step arithmetic:
  - Computed in COUNT_W+1 bits.
  - Up step: new = max(count - STEP, MIN_COUNT).
  - Down step: new = min(count + STEP, MAX_COUNT).
  - At a limit, a step in that direction leaves the count unchanged (count_update = 0). The opposite direction still works, and the FSM keeps running.
- speed_reset_event:
  - Highest priority: count = DEFAULT_COUNT and FSM to IDLE in the same edge; any step due that cycle is discarded.
  - count_update = 1 only if the value changed.
- Latency: a rising edge or pulse in cycle N is reflected in div_clk_count, flags and count_update at edge N+1.
- Flags and count_update are registered alongside div_clk_count, never combinational from inputs.
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). The timer never wraps; it is cleared on every state change.

Decomposition:
- Package speed_ctrl_pkg holds:
  - typedef enum logic [1:0] speed_state_t {IDLE, HOLD_WAIT, REPEAT};
  - typedef enum logic [1:0] speed_dir_t {DIR_NONE, DIR_UP, DIR_DN};
- One sub-module, key_autorepeat:
  - Contains edge detect, FSM and timer.
  - Takes the resolved direction and speed_reset_event; emits step_pulse and step_dir.
- The top level holds the clamp arithmetic and output registers.

Test Plan (bench overrides REPEAT_DELAY=8, REPEAT_PERIOD=4; other parameters at default):
- Reset, then idle 5 cycles -> div_clk_count=614, at_min=0, at_max=0, count_update=0.
- Up key pulsed high for 3 cycles -> count becomes 613 one cycle after the rising edge, single count_update, no further change.
- Down key held for 20 cycles from count 614:
  - Steps at edges +1, +9, +13, +17 after the rising edge -> count reaches 618.
  - Release -> FSM to IDLE, count stays 618.
- STEP=1000, count 614, up key pressed -> count clamps to 1, at_min=1.
  - Further presses: count stays 1, count_update=0.
  - Then down key pressed -> count = 1001.
- Up key held into REPEAT, speed_reset_event asserted on the same cycle a repeat step is due -> count=614, no step applied.
  - Key still held: no step until release and re-press.
- Both keys held together, and up held with down added mid-repeat -> no steps while both are high; FSM returns to IDLE.
- rst asserted mid-REPEAT -> outputs return to their reset values at the next edge.
